// File: rtl/program_loader_pkg.sv
// Shared encodings for the program loader: FSM states, instruction word layout, stream header size.
// Used by the top-level loader FSM and the word assembler.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam int INSTR_W    = 28;
    localparam int RSVD_LSB   = 28;
    localparam int RSVD_W     = 4;
    localparam int HDR_LEN    = 2;
    localparam int WORD_BYTES = 4;

    function automatic logic accepts_bytes(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Shifts big-endian stream bytes into 32-bit words and flags completion on the 4th byte.
// Latency: word_vld/word_dat/rsvd_err are combinational with the 4th byte; no backpressure of its own.
// Backpressure: byte_vld must already be qualified by the parent's ready.
module loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               byte_vld,
    input  logic [7:0]         byte_dat,
    output logic               word_vld,
    output logic [INSTR_W-1:0] word_dat,
    output logic               rsvd_err
);

    logic [23:0] shift_q, shift_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] full_word;

    always_comb begin
        shift_d   = shift_q;
        idx_d     = idx_q;
        full_word = {shift_q, byte_dat};
        if (clear) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_vld) begin
            shift_d = {shift_q[15:0], byte_dat};
            idx_d   = idx_q + 2'd1;
        end
    end

    // The 4th byte completes the word in the same cycle it arrives.
    assign word_vld = byte_vld && !clear && (idx_q == 2'(WORD_BYTES - 1));
    assign word_dat = full_word[INSTR_W-1:0];
    assign rsvd_err = (full_word[RSVD_LSB +: RSVD_W] != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed image into instruction RAM and holds the CPU in reset until done; optional XOR check via LOADER_CHECKSUM_EN.
// Latency: write strobe one cycle after the 4th byte of a word; oDone one cycle after the last strobe (or with the checksum result).
// Backpressure: oByteReady is high only while the loader expects stream bytes; bytes move on iByteValid && oByteReady.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MAX_WORDS  = 256,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [7:0]            iByte,
    input  logic                  iByteValid,
    output logic                  oByteReady,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [INSTR_W-1:0]    oInstruction,
    output logic                  oCpuHold,
    output logic                  oDone,
    output logic                  oError,
    output logic [15:0]           oWordCount
);

`ifdef LOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CHECK;
`else
    localparam state_t ST_AFTER_DATA = ST_DONE;
`endif
    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t                state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           count_q, count_d;
    logic                  rdy_q, rdy_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [INSTR_W-1:0]    instr_q, instr_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    logic               byte_acc;
    logic               start_take;
    logic [15:0]        len_full;
    logic               asm_vld;
    logic               word_vld;
    logic [INSTR_W-1:0] word_dat;
    logic               rsvd_err;

    assign byte_acc   = iByteValid && rdy_q;
    assign start_take = iStart && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR));
    assign len_full   = {len_q[15:8], iByte};
    assign asm_vld    = byte_acc && (state_q == ST_DATA);

    loader_word_assembler u_asm (
        .clk      (Clock),
        .reset    (Reset),
        .clear    (start_take),
        .byte_vld (asm_vld),
        .byte_dat (iByte),
        .word_vld (word_vld),
        .word_dat (word_dat),
        .rsvd_err (rsvd_err)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        instr_d = instr_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = byte_acc ? (csum_q ^ iByte) : csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_take) begin
                    state_d = ST_LEN_HI;
                    count_d = '0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_LEN_HI: begin
                if (byte_acc) begin
                    len_d   = {iByte, 8'h00};
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (byte_acc) begin
                    len_d = len_full;
                    // Oversized images are refused before any write, so the counter never wraps.
                    if ({1'b0, len_full} > MAX_N)
                        state_d = ST_ERROR;
                    else if (len_full == '0)
                        state_d = ST_AFTER_DATA;
                    else
                        state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_vld) begin
                    if (rsvd_err) begin
                        state_d = ST_ERROR;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_WIDTH'(count_q);
                        instr_d = word_dat;
                        count_d = count_q + 16'd1;
                        if (count_d == len_q)
                            state_d = ST_AFTER_DATA;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_acc)
                    state_d = (iByte == csum_q) ? ST_DONE : ST_ERROR;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        rdy_d  = accepts_bytes(state_d);
        // Leaving DATA, completion waits one cycle so it trails the final write strobe.
        done_d = (state_d == ST_DONE) && (state_q != ST_DATA);
        hold_d = !done_d;
        err_d  = (state_d == ST_ERROR);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            count_q <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            instr_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign oByteReady    = rdy_q;
    assign oWriteEnable  = we_q;
    assign oWriteAddress = addr_q;
    assign oInstruction  = instr_q;
    assign oCpuHold      = hold_q;
    assign oDone         = done_q;
    assign oError        = err_q;
    assign oWordCount    = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: stimulus tasks push expected writes, a negedge monitor pops and checks them.
module tb_program_loader;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        iStart;
    logic [7:0]  iByte;
    logic        iByteValid;
    logic        oByteReady;
    logic        oWriteEnable;
    logic [15:0] oWriteAddress;
    logic [27:0] oInstruction;
    logic        oCpuHold;
    logic        oDone;
    logic        oError;
    logic [15:0] oWordCount;

    always #5 Clock = ~Clock;

    program_loader dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iStart        (iStart),
        .iByte         (iByte),
        .iByteValid    (iByteValid),
        .oByteReady    (oByteReady),
        .oWriteEnable  (oWriteEnable),
        .oWriteAddress (oWriteAddress),
        .oInstruction  (oInstruction),
        .oCpuHold      (oCpuHold),
        .oDone         (oDone),
        .oError        (oError),
        .oWordCount    (oWordCount)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic [27:0] data;
        logic [31:0] cyc;
    } exp_t;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [31:0] cyc     = 0;
    logic [7:0] csum;
    logic [7:0] c;

    always @(posedge Clock) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the oldest expected write, including its cycle.
    always @(negedge Clock) begin
        exp_t e;
        if (oWriteEnable !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL strobe_unexpected we=%b addr=0x%0h data=0x%0h cyc=%0d",
                         oWriteEnable, oWriteAddress, oInstruction, cyc);
            end else begin
                e = exp_q.pop_front();
                if (oWriteAddress !== e.addr || oInstruction !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL strobe actual addr=0x%0h data=0x%0h cyc=%0d expected addr=0x%0h data=0x%0h cyc=%0d",
                             oWriteAddress, oInstruction, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge Clock);
        #1;
    endtask

    task automatic pulse_start(input bit with_byte);
        iStart     = 1'b1;
        iByteValid = with_byte;
        iByte      = 8'h01;
        sync();
        iStart     = 1'b0;
        iByteValid = 1'b0;
        csum       = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push,
                             input logic [15:0] addr, input logic [27:0] data);
        int n = 0;
        exp_t e;
        iByte      = b;
        iByteValid = 1'b1;
        @(negedge Clock);
        while (!oByteReady && n < 20) begin
            n++;
            @(negedge Clock);
        end
        if (!oByteReady) begin
            checks++;
            failures++;
            $display("FAIL byte_ready_timeout byte=0x%0h ready=%b required=1", b, oByteReady);
            iByteValid = 1'b0;
            sync();
            return;
        end
        if (push) begin
            e.addr = addr;
            e.data = data;
            e.cyc  = cyc + 1;
            exp_q.push_back(e);
        end
        csum = csum ^ b;
        sync();
    endtask

    task automatic gap_cycles(input int gap);
        if (gap > 0) begin
            iByteValid = 1'b0;
            repeat (gap) sync();
        end
    endtask

    task automatic send_hdr(input logic [15:0] n, input int gap);
        send_byte(n[15:8], 1'b0, 16'h0, 28'h0);
        gap_cycles(gap);
        send_byte(n[7:0], 1'b0, 16'h0, 28'h0);
        gap_cycles(gap);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [15:0] addr,
                             input bit expect_wr, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[31-8*i -: 8], expect_wr && (i == 3), addr, w[27:0]);
            gap_cycles(gap);
        end
    endtask

    task automatic finish_ok(input logic [15:0] wc);
`ifdef LOADER_CHECKSUM_EN
        c = csum;
        send_byte(c, 1'b0, 16'h0, 28'h0);
`endif
        iByteValid = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        chk("done_level", oDone, 1);
        chk("hold_released", oCpuHold, 0);
        chk("no_error", oError, 0);
        chk("word_count", oWordCount, wc);
        chk("ready_low_done", oByteReady, 0);
        sync();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; iStart = 1'b0; iByteValid = 1'b0; iByte = 8'h00; csum = 8'h00;
        repeat (3) sync();
        @(negedge Clock);
        chk("rst_ready", oByteReady, 0);
        chk("rst_we", oWriteEnable, 0);
        chk("rst_addr", oWriteAddress, 0);
        chk("rst_instr", oInstruction, 0);
        chk("rst_hold", oCpuHold, 1);
        chk("rst_done", oDone, 0);
        chk("rst_error", oError, 0);
        chk("rst_count", oWordCount, 0);
        sync();
        Reset = 1'b0;
        sync();

        // Two words back-to-back, exact completion timing.
        pulse_start(1'b0);
        chk("t1_ready_len_hi", oByteReady, 1);
        chk("t1_hold", oCpuHold, 1);
        send_hdr(16'd2, 0);
        send_word(32'h01020304, 16'd0, 1'b1, 0);
        send_word(32'h0A0B0C0D, 16'd1, 1'b1, 0);
`ifdef LOADER_CHECKSUM_EN
        c = csum;
        send_byte(c, 1'b0, 16'h0, 28'h0);
        iByteValid = 1'b0;
        @(negedge Clock);
        chk("t1_done_after_csum", oDone, 1);
        chk("t1_hold_after_csum", oCpuHold, 0);
`else
        iByteValid = 1'b0;
        @(negedge Clock);
        chk("t1_done_not_yet", oDone, 0);
        chk("t1_hold_not_yet", oCpuHold, 1);
        @(negedge Clock);
        chk("t1_done", oDone, 1);
        chk("t1_hold", oCpuHold, 0);
`endif
        chk("t1_count", oWordCount, 2);
        chk("t1_ready_done", oByteReady, 0);
        sync();

        // Empty image.
        pulse_start(1'b0);
        send_hdr(16'd0, 0);
        finish_ok(16'd0);

        // Oversized image, started from DONE with a byte on the same edge.
        pulse_start(1'b1);
        chk("t2_done_cleared", oDone, 0);
        chk("t2_hold_on_start", oCpuHold, 1);
        send_hdr(16'h0101, 0);
        iByteValid = 1'b0;
        @(negedge Clock);
        chk("t2_error", oError, 1);
        chk("t2_hold", oCpuHold, 1);
        chk("t2_ready", oByteReady, 0);
        chk("t2_count", oWordCount, 0);
        sync();

        // Exactly MAX_WORDS is accepted; reset mid-word then a clean reload.
        pulse_start(1'b0);
        chk("t3_error_cleared", oError, 0);
        send_hdr(16'h0100, 0);
        iByteValid = 1'b0;
        @(negedge Clock);
        chk("t3_max_no_error", oError, 0);
        chk("t3_max_ready", oByteReady, 1);
        sync();
        send_word(32'h00112233, 16'd0, 1'b1, 0);
        send_byte(8'h05, 1'b0, 16'h0, 28'h0);
        send_byte(8'h06, 1'b0, 16'h0, 28'h0);
        iByteValid = 1'b0;
        Reset = 1'b1;
        sync();
        sync();
        @(negedge Clock);
        chk("t3_rst_ready", oByteReady, 0);
        chk("t3_rst_count", oWordCount, 0);
        chk("t3_rst_hold", oCpuHold, 1);
        sync();
        Reset = 1'b0;
        sync();
        pulse_start(1'b0);
        send_hdr(16'd2, 0);
        send_word(32'h0FFFFFFF, 16'd0, 1'b1, 0);
        send_word(32'h00000001, 16'd1, 1'b1, 0);
        finish_ok(16'd2);

        // Reserved nibble set in word 0, then restart.
        pulse_start(1'b0);
        send_hdr(16'd1, 0);
        send_word(32'h10000000, 16'd0, 1'b0, 0);
        iByteValid = 1'b0;
        @(negedge Clock);
        chk("t4_error", oError, 1);
        chk("t4_hold", oCpuHold, 1);
        chk("t4_count", oWordCount, 0);
        sync();
        pulse_start(1'b0);
        @(negedge Clock);
        chk("t4_restart_error_clr", oError, 0);
        chk("t4_restart_ready", oByteReady, 1);
        sync();
        send_hdr(16'd1, 0);
        send_word(32'h0DEADBEE, 16'd0, 1'b1, 0);
        finish_ok(16'd1);

        // Gapped bytes; a mid-load iStart must be ignored.
        pulse_start(1'b0);
        send_hdr(16'd1, 1);
        iStart = 1'b1;
        sync();
        iStart = 1'b0;
        send_word(32'h0ABCDEF1, 16'd0, 1'b1, 1);
        finish_ok(16'd1);

`ifdef LOADER_CHECKSUM_EN
        // Corrupted checksum byte: words written, CPU kept in reset.
        pulse_start(1'b0);
        send_hdr(16'd1, 0);
        send_word(32'h01234567, 16'd0, 1'b1, 0);
        c = csum ^ 8'h01;
        send_byte(c, 1'b0, 16'h0, 28'h0);
        iByteValid = 1'b0;
        @(negedge Clock);
        chk("t6_csum_error", oError, 1);
        chk("t6_csum_hold", oCpuHold, 1);
        chk("t6_csum_done", oDone, 0);
        sync();
`endif

        repeat (4) sync();
        chk("pending_strobes", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
